fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined MIPS32 core, replacing the single-entry IF/ID hold register with a DEPTH-entry prefetch queue. It drives the instruction memory one request per cycle, buffers returned words with their PC+4, and presents them to decode with a hold (stall) input and a redirect (branch/jump flush) input. It sits between IMEM and the decode stage.

---
 rtl/mips_pkg.sv | 13 +
 rtl/fetch_queue_if.sv | 38 +++
 rtl/fetch_queue_fifo.sv | 76 +++++++
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the MIPS32 front-end blocks.
//   MIPS_ADDR_W   - default PC / IMEM address width
//   MIPS_DATA_W   - default instruction width
//   MIPS_NOP      - instruction presented to decode when nothing is valid
//   MIPS_RESET_PC - default first fetch address after reset
package mips_pkg;

  localparam int          MIPS_ADDR_W   = 32;
  localparam int          MIPS_DATA_W   = 32;
  localparam logic [31:0] MIPS_NOP      = 32'h0000_0000;
  localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the IMEM request/response bus and the decode-side
// signals of the fetch front end.
//   master - the fetch queue: drives imem_req/imem_addr and the if_* / count
//            outputs, receives imem_rdata, hold, redirect, redirect_pc.
//   slave  - the environment (IMEM + decode): the mirror image.
// Handshake: there is no ready on the IMEM side; every cycle with imem_req=1
// is an accepted request, and imem_rdata carries its word exactly one cycle
// later. On the decode side if_valid=1 with hold=0 consumes the head entry.
interface fetch_queue_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = MIPS_ADDR_W,
  parameter int DATA_W = MIPS_DATA_W,
  parameter int DEPTH  = 4
);

  logic                     hold;
  logic                     redirect;
  logic [ADDR_W-1:0]        redirect_pc;
  logic                     imem_req;
  logic [ADDR_W-1:0]        imem_addr;
  logic [DATA_W-1:0]        imem_rdata;
  logic                     if_valid;
  logic [DATA_W-1:0]        if_instr;
  logic [ADDR_W-1:0]        if_pc_plus4;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    input  hold, redirect, redirect_pc, imem_rdata,
    output imem_req, imem_addr, if_valid, if_instr, if_pc_plus4, count
  );

  modport slave (
    output hold, redirect, redirect_pc, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc_plus4, count
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: DEPTH x W circular buffer for fetched {instr, pc+4} entries.
//   clk, rst     - clock, synchronous active-low reset
//   flush        - empty the queue this cycle (wins over push/pop)
//   push, push_data - write an entry at the tail
//   pop          - consume the head entry
//   valid        - queue not empty
//   head_data    - head entry (raw storage, caller gates with valid)
//   count        - occupied entries, 0..DEPTH
// No bypass: a word pushed into an empty queue becomes visible next cycle.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           push_data,
  output logic                   valid,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  // Guards keep the pointers sane even if a caller misbehaves; a push into a
  // full queue is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; everything downstream is gated by valid.
  always_ff @(posedge clk) begin
    if (rst && push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign valid     = (count_q != '0);
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a DEPTH-entry prefetch queue.
//   clk, rst - clock, synchronous active-low reset
//   bus      - fetch_queue_if.master:
//     hold, redirect, redirect_pc    decode stall / flush + new target
//     imem_req, imem_addr            one request per cycle, addr = PC register
//     imem_rdata                     word for the request of the previous cycle
//     if_valid, if_instr, if_pc_plus4 head entry (NOP / 0 when not valid)
//     count                          occupied queue entries
// A queue slot is reserved when a request issues, so the word returning one
// cycle later always has room.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int               ADDR_W   = MIPS_ADDR_W,
  parameter int               DATA_W   = MIPS_DATA_W,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(MIPS_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  fetch_queue_if.master    bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = DATA_W + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;

  logic              fifo_valid;
  logic [EW-1:0]     fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              pop, push, req;
  logic [CW:0]       occupancy;

  // Occupancy after this cycle's pop, counting the slot reserved by a request
  // in flight; one extra bit so count+inflight can reach DEPTH cleanly.
  always_comb begin
    pop       = fifo_valid && !bus.hold && !bus.redirect;
    push      = inflight_q && !bus.redirect;
    occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    req       = rst && !bus.redirect && (occupancy < (CW+1)'(DEPTH));
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = req;
    if (bus.redirect) begin
      pc_d = bus.redirect_pc;
    end else if (req) begin
      pc_d          = pc_q + ADDR_W'(4);
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect),
    .push      (push),
    .pop       (pop),
    .push_data ({bus.imem_rdata, inflight_pc_q + ADDR_W'(4)}),
    .valid     (fifo_valid),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = fifo_valid;
  assign bus.if_instr    = fifo_valid ? fifo_head[EW-1:ADDR_W] : DATA_W'(MIPS_NOP);
  assign bus.if_pc_plus4 = fifo_valid ? fifo_head[ADDR_W-1:0] : '0;
  assign bus.count       = fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + randomized bench for fetch_queue (DEPTH=4).
// IMEM model returns the request address as the instruction word. The
// reference model keeps the fetch stream as a queue of addresses, a pending
// request and a PC, and predicts every output each cycle.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;

  fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- IMEM model ----------------
  // Word for an accepted request appears one cycle later; a junk value is
  // returned otherwise so a fill without a request is visible.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= bus.imem_addr;
    else              bus.imem_rdata <= 32'hDEAD_BEEF;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_pending;
  logic [31:0] m_pending_pc;
  bit          model_ok;
  int          tests;
  int          fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare all outputs
  // against the model, then advance the model across the rising edge.
  task automatic step(input logic r, input logic h, input logic rd, input logic [31:0] rpc);
    logic ev, pop, e_req;
    int   occ;
    @(negedge clk);
    rst             = r;
    bus.hold        = h;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    #2;
    ev    = 1'b0;
    pop   = 1'b0;
    e_req = 1'b0;
    if (model_ok) begin
      ev    = (exp_q.size() != 0);
      pop   = ev && !h && !rd;
      occ   = exp_q.size() + int'(m_pending) - int'(pop);
      e_req = r && !rd && (occ < DEPTH);
      chk("if_valid",    32'(bus.if_valid),  32'(ev));
      chk("if_instr",    bus.if_instr,       ev ? exp_q[0] : 32'h0);
      chk("if_pc_plus4", bus.if_pc_plus4,    ev ? exp_q[0] + 32'd4 : 32'h0);
      chk("count",       32'(bus.count),     32'(exp_q.size()));
      chk("imem_req",    32'(bus.imem_req),  32'(e_req));
      chk("imem_addr",   bus.imem_addr,      m_pc);
    end
    if (!r) begin
      exp_q.delete();
      m_pc      = RESET_PC;
      m_pending = 1'b0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      if (rd) begin
        exp_q.delete();
        m_pending = 1'b0;
        m_pc      = rpc;
      end else begin
        if (m_pending) exp_q.push_back(m_pending_pc);
        if (pop) void'(exp_q.pop_front());
        if (e_req) begin
          m_pending    = 1'b1;
          m_pending_pc = m_pc;
          m_pc         = m_pc + 32'd4;
        end else begin
          m_pending = 1'b0;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic run(input int n, input logic h);
    for (int i = 0; i < n; i++) step(1'b1, h, 1'b0, 32'h0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int   guard;
    logic r, h, rd;
    logic [31:0] rpc;
    tests           = 0;
    fails           = 0;
    model_ok        = 1'b0;
    m_pc            = RESET_PC;
    m_pending       = 1'b0;
    m_pending_pc    = '0;
    rst             = 1'b0;
    bus.hold        = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // Reset, then free-running fetch.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    run(8, 1'b0);

    // Continuous hold fills the queue; release resumes without gaps.
    run(10, 1'b1);
    chk("count_full_under_hold", 32'(bus.count), 32'(DEPTH));
    run(8, 1'b0);

    // Redirect while count=3 with a request in flight.
    guard = 0;
    while (!(exp_q.size() == 3 && m_pending) && guard < 20) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      guard++;
    end
    if (guard >= 20) begin
      tests++;
      fails++;
      $error("FAIL reach_count3 observed=timeout expected=count3_inflight");
    end
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    run(8, 1'b0);

    // Back-to-back redirects: the second target wins.
    step(1'b1, 1'b0, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0300);
    run(6, 1'b0);

    // Full queue, redirect and hold together: flush wins.
    run(8, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0400);
    run(6, 1'b0);

    // PC wrap past the top of the address space.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    run(6, 1'b0);

    // One-cycle reset mid-stream.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    run(6, 1'b0);

    // Randomized stimulus.
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 99) >= 2);
      h   = ($urandom_range(0, 99) < 40);
      rd  = ($urandom_range(0, 99) < 8);
      rpc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                        : ($urandom & 32'hFFFF_FFFC);
      step(r, h, rd, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
